// File: rtl/trace_filter_cfg.sv
// trace_filter_cfg: runtime-configurable retired-instruction trace filter.
// Classifies each retired instruction, keeps event instructions plus a
// trailing window after each event, and keeps saturating kept/dropped counts.
module trace_filter_cfg #(
  parameter int INSTR_WIDTH  = 32,
  parameter int MAX_TRAILING = 4,
  parameter int TRAIL_W      = $clog2(MAX_TRAILING + 1),
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_valid,
  input  logic [INSTR_WIDTH-1:0] next_instr,
  input  logic                   cfg_wr,
  input  logic [3:0]             cfg_class_en,
  input  logic [TRAIL_W-1:0]     cfg_trailing,
  input  logic [1:0]             cfg_mode,
  input  logic [INSTR_WIDTH-1:0] cfg_match_value,
  input  logic [INSTR_WIDTH-1:0] cfg_match_mask,
  input  logic                   cnt_clear,
  output logic                   drop_instr,
  output logic                   decision_valid,
  output logic [3:0]             event_class,
  output logic [CNT_WIDTH-1:0]   kept_count,
  output logic [CNT_WIDTH-1:0]   dropped_count
);

  localparam logic [6:0]  BRANCH_OPCODE         = 7'b1100011;
  localparam logic [6:0]  JAL_OPCODE            = 7'b1101111;
  localparam logic [6:0]  JALR_OPCODE           = 7'b1100111;
  localparam logic [1:0]  C_BRANCH_OPCODE       = 2'b01;
  localparam logic [1:0]  C_BRANCH_FUNCT3_2_MSB = 2'b11;
  localparam logic [1:0]  C_JAL_OPCODE          = 2'b01;
  localparam logic [2:0]  C_JAL_FUNCT3          = 3'b001;
  localparam logic [1:0]  C_JR_OPCODE           = 2'b10;
  localparam logic [2:0]  C_JR_FUNCT4_3_MSB     = 3'b100;
  localparam logic [31:0] WFI_INSTRUCTION       = 32'h1050_0073;

  localparam logic [1:0]  MODE_PASS = 2'b01;
  localparam logic [1:0]  MODE_DROP = 2'b10;

  localparam logic [TRAIL_W-1:0] TRAIL_MAX = TRAIL_W'(MAX_TRAILING);

  // Shadow configuration
  logic [3:0]             class_en_q;
  logic [TRAIL_W-1:0]     trailing_q;
  logic [1:0]             mode_q;
  logic [INSTR_WIDTH-1:0] match_value_q;
  logic [INSTR_WIDTH-1:0] match_mask_q;

  // Filter state
  logic [3:0]             event_q, event_d;
  logic [TRAIL_W-1:0]     trail_q, trail_d;
  logic                   dvalid_q;
  logic [CNT_WIDTH-1:0]   kept_q, dropped_q;

  logic [TRAIL_W-1:0]     trailing_clamped;
  logic                   is_c;
  logic                   hit_branch, hit_jump, hit_wfi, hit_custom;

  assign trailing_clamped = (cfg_trailing > TRAIL_MAX) ? TRAIL_MAX : cfg_trailing;

  // Class decode of the incoming instruction; compressed forms only when [1:0] != 11
  always_comb begin
    is_c       = (next_instr[1:0] != 2'b11);
    hit_branch = (next_instr[6:0] == BRANCH_OPCODE) ||
                 (is_c && next_instr[1:0] == C_BRANCH_OPCODE &&
                  next_instr[15:14] == C_BRANCH_FUNCT3_2_MSB);
    hit_jump   = (next_instr[6:0] == JAL_OPCODE) || (next_instr[6:0] == JALR_OPCODE) ||
                 (is_c && next_instr[1:0] == C_JAL_OPCODE &&
                  next_instr[15:13] == C_JAL_FUNCT3) ||
                 (is_c && next_instr[1:0] == C_JR_OPCODE &&
                  next_instr[15:13] == C_JR_FUNCT4_3_MSB &&
                  next_instr[6:2] == 5'd0 && next_instr[11:7] != 5'd0);
    hit_wfi    = (next_instr == INSTR_WIDTH'(WFI_INSTRUCTION));
    hit_custom = ((next_instr & match_mask_q) == (match_value_q & match_mask_q));
  end

  // Shadow config latch; custom class off at reset since a zero mask matches all
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      class_en_q    <= 4'b0111;
      trailing_q    <= TRAIL_W'(1);
      mode_q        <= 2'b00;
      match_value_q <= '0;
      match_mask_q  <= '0;
    end else if (cfg_wr) begin
      class_en_q    <= cfg_class_en;
      trailing_q    <= trailing_clamped;
      mode_q        <= cfg_mode;
      match_value_q <= cfg_match_value;
      match_mask_q  <= cfg_match_mask;
    end
  end

  // Next event/trailing state: reload on the previous event, else count down; hold on stall
  always_comb begin
    event_d = event_q;
    trail_d = trail_q;
    if (pc_valid) begin
      event_d = {hit_custom, hit_wfi, hit_jump, hit_branch} & class_en_q;
      if (|event_q)           trail_d = trailing_q;
      else if (trail_q != '0) trail_d = trail_q - TRAIL_W'(1);
      else                    trail_d = '0;
    end
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_q  <= '0;
      trail_q  <= '0;
      dvalid_q <= 1'b0;
    end else begin
      event_q  <= event_d;
      trail_q  <= trail_d;
      dvalid_q <= pc_valid;
    end
  end

  // Drop decision follows the current mode combinationally
  always_comb begin
    case (mode_q)
      MODE_PASS: drop_instr = 1'b0;
      MODE_DROP: drop_instr = 1'b1;
      default:   drop_instr = ~((|event_q) || (trail_q != '0));
    endcase
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clear) begin
      kept_q    <= '0;
      dropped_q <= '0;
    end else if (dvalid_q) begin
      if (!drop_instr) begin
        if (kept_q != '1) kept_q <= kept_q + CNT_WIDTH'(1);
      end else begin
        if (dropped_q != '1) dropped_q <= dropped_q + CNT_WIDTH'(1);
      end
    end
  end

  assign decision_valid = dvalid_q;
  assign event_class    = event_q;
  assign kept_count     = kept_q;
  assign dropped_count  = dropped_q;

endmodule

// File: tb/tb_trace_filter_cfg.sv
// Directed bench for trace_filter_cfg; a second instance with 3-bit counters
// shares all inputs so counter saturation can be observed.
module tb_trace_filter_cfg;

  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] BNE   = 32'h0000_1063;
  localparam logic [31:0] JAL   = 32'h0000_006F;
  localparam logic [31:0] WFI   = 32'h1050_0073;
  localparam logic [31:0] CSRRW = 32'h3400_1073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid;
  logic [31:0] next_instr;
  logic        cfg_wr;
  logic [3:0]  cfg_class_en;
  logic [2:0]  cfg_trailing;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_match_value;
  logic [31:0] cfg_match_mask;
  logic        cnt_clear;
  logic        drop_instr, decision_valid;
  logic [3:0]  event_class;
  logic [31:0] kept_count, dropped_count;
  logic        s_drop, s_dv;
  logic [3:0]  s_ev;
  logic [2:0]  s_kept, s_dropped;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trace_filter_cfg dut (
    .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .next_instr(next_instr),
    .cfg_wr(cfg_wr), .cfg_class_en(cfg_class_en), .cfg_trailing(cfg_trailing),
    .cfg_mode(cfg_mode), .cfg_match_value(cfg_match_value), .cfg_match_mask(cfg_match_mask),
    .cnt_clear(cnt_clear), .drop_instr(drop_instr), .decision_valid(decision_valid),
    .event_class(event_class), .kept_count(kept_count), .dropped_count(dropped_count)
  );

  trace_filter_cfg #(.CNT_WIDTH(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .next_instr(next_instr),
    .cfg_wr(cfg_wr), .cfg_class_en(cfg_class_en), .cfg_trailing(cfg_trailing),
    .cfg_mode(cfg_mode), .cfg_match_value(cfg_match_value), .cfg_match_mask(cfg_match_mask),
    .cnt_clear(cnt_clear), .drop_instr(s_drop), .decision_valid(s_dv),
    .event_class(s_ev), .kept_count(s_kept), .dropped_count(s_dropped)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One cycle: drive at negedge, sample 1 time unit after the posedge
  task automatic issue(input logic v, input logic [31:0] ins, input logic clr);
    @(negedge clk);
    pc_valid = v; next_instr = ins; cnt_clear = clr;
    @(posedge clk); #1;
    pc_valid = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic write_cfg(input logic [3:0] en, input logic [2:0] trl, input logic [1:0] md,
                           input logic [31:0] val, input logic [31:0] msk,
                           input logic v, input logic [31:0] ins);
    @(negedge clk);
    cfg_class_en = en; cfg_trailing = trl; cfg_mode = md;
    cfg_match_value = val; cfg_match_mask = msk; cfg_wr = 1'b1;
    pc_valid = v; next_instr = ins;
    @(posedge clk); #1;
    cfg_wr = 1'b0; pc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (drop_instr !== 1'b1) begin errors++; $display("FAIL reset_drop got %b exp 1", drop_instr); end
    checks++; if (decision_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", decision_valid); end
    checks++; if (event_class !== 4'h0) begin errors++; $display("FAIL reset_ev got %h exp 0", event_class); end
    checks++; if (kept_count !== 32'd0 || dropped_count !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", kept_count, dropped_count); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_default();
    logic [31:0] s [4] = '{ADDI, BEQ, ADDI, ADDI};
    logic        e [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, s[i], 1'b0);
      checks++; if (drop_instr !== e[i] || decision_valid !== 1'b1) begin
        errors++; $display("FAIL default[%0d] got drop=%b dv=%b exp drop=%b dv=1", i, drop_instr, decision_valid, e[i]); end
    end
  endtask

  task automatic test_long_window();
    logic [31:0] s [6] = '{JAL, ADDI, ADDI, ADDI, ADDI, ADDI};
    logic        e3 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        e7 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    write_cfg(4'b0111, 3'd3, 2'b00, 32'h0, 32'h0, 1'b0, ADDI);
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, s[i], 1'b0);
      checks++; if (drop_instr !== e3[i]) begin errors++; $display("FAIL trail3[%0d] got %b exp %b", i, drop_instr, e3[i]); end
    end
    checks++; if (event_class !== 4'h0) begin errors++; $display("FAIL trail3_ev got %h exp 0", event_class); end
    write_cfg(4'b0111, 3'd7, 2'b00, 32'h0, 32'h0, 1'b0, ADDI);
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, s[i], 1'b0);
      checks++; if (drop_instr !== e7[i]) begin errors++; $display("FAIL trail_clamp[%0d] got %b exp %b", i, drop_instr, e7[i]); end
    end
  endtask

  task automatic test_reload_stall();
    logic [31:0] s [6] = '{BEQ, ADDI, BNE, ADDI, ADDI, ADDI};
    logic        e [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    write_cfg(4'b0111, 3'd2, 2'b00, 32'h0, 32'h0, 1'b0, ADDI);
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, s[i], 1'b0);
      checks++; if (drop_instr !== e[i]) begin errors++; $display("FAIL reload[%0d] got %b exp %b", i, drop_instr, e[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, s[i], 1'b0);
      checks++; if (drop_instr !== e[i]) begin errors++; $display("FAIL stall[%0d] got %b exp %b", i, drop_instr, e[i]); end
      issue(1'b0, BEQ, 1'b0);
      issue(1'b0, BEQ, 1'b0);
      checks++; if (drop_instr !== e[i] || decision_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got drop=%b dv=%b exp drop=%b dv=0", i, drop_instr, decision_valid, e[i]); end
    end
  endtask

  task automatic test_custom_wfi();
    logic [31:0] s [3] = '{WFI, CSRRW, BEQ};
    logic        e [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0]  c [3] = '{4'b1000, 4'b1000, 4'b0000};
    write_cfg(4'b1000, 3'd0, 2'b00, 32'h73, 32'h7F, 1'b0, ADDI);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, s[i], 1'b0);
      checks++; if (drop_instr !== e[i] || event_class !== c[i]) begin
        errors++; $display("FAIL custom[%0d] got drop=%b ev=%h exp drop=%b ev=%h", i, drop_instr, event_class, e[i], c[i]); end
    end
  endtask

  task automatic test_modes();
    write_cfg(4'b0111, 3'd0, 2'b01, 32'h0, 32'h0, 1'b0, ADDI);
    issue(1'b1, ADDI, 1'b0);
    checks++; if (drop_instr !== 1'b0) begin errors++; $display("FAIL pass_addi got %b exp 0", drop_instr); end
    issue(1'b1, BEQ, 1'b0);
    checks++; if (drop_instr !== 1'b0 || event_class !== 4'b0001) begin
      errors++; $display("FAIL pass_beq got drop=%b ev=%h exp drop=0 ev=1", drop_instr, event_class); end
    write_cfg(4'b0111, 3'd0, 2'b10, 32'h0, 32'h0, 1'b0, ADDI);
    issue(1'b1, JAL, 1'b0);
    checks++; if (drop_instr !== 1'b1 || event_class !== 4'b0010) begin
      errors++; $display("FAIL dropall_jal got drop=%b ev=%h exp drop=1 ev=2", drop_instr, event_class); end
    // mode change alone flips the decision for the held instruction
    write_cfg(4'b0111, 3'd0, 2'b01, 32'h0, 32'h0, 1'b0, ADDI);
    checks++; if (drop_instr !== 1'b0) begin errors++; $display("FAIL mode_switch got %b exp 0", drop_instr); end
    // instruction alongside the write is classified with the old enables
    write_cfg(4'b0000, 3'd0, 2'b00, 32'h0, 32'h0, 1'b1, BEQ);
    checks++; if (drop_instr !== 1'b0 || event_class !== 4'b0001) begin
      errors++; $display("FAIL cfg_coincident got drop=%b ev=%h exp drop=0 ev=1", drop_instr, event_class); end
    issue(1'b1, BEQ, 1'b0);
    checks++; if (drop_instr !== 1'b1 || event_class !== 4'b0000) begin
      errors++; $display("FAIL cfg_after got drop=%b ev=%h exp drop=1 ev=0", drop_instr, event_class); end
  endtask

  task automatic test_counters();
    logic [31:0] s [10] = '{BEQ, ADDI, BEQ, ADDI, ADDI, ADDI, ADDI, ADDI, ADDI, ADDI};
    write_cfg(4'b0111, 3'd1, 2'b00, 32'h0, 32'h0, 1'b0, ADDI);
    issue(1'b0, ADDI, 1'b1);
    for (int i = 0; i < 10; i++) issue(1'b1, s[i], 1'b0);
    issue(1'b0, ADDI, 1'b0);
    checks++; if (kept_count !== 32'd4) begin errors++; $display("FAIL kept_count got %0d exp 4", kept_count); end
    checks++; if (dropped_count !== 32'd6) begin errors++; $display("FAIL dropped_count got %0d exp 6", dropped_count); end
    issue(1'b1, ADDI, 1'b0);
    issue(1'b1, ADDI, 1'b1);
    checks++; if (kept_count !== 32'd0 || dropped_count !== 32'd0) begin
      errors++; $display("FAIL clear_prio got %0d/%0d exp 0/0", kept_count, dropped_count); end
    write_cfg(4'b0111, 3'd1, 2'b10, 32'h0, 32'h0, 1'b0, ADDI);
    issue(1'b0, ADDI, 1'b1);
    for (int i = 0; i < 9; i++) issue(1'b1, ADDI, 1'b0);
    issue(1'b0, ADDI, 1'b0);
    checks++; if (dropped_count !== 32'd9) begin errors++; $display("FAIL dropped_9 got %0d exp 9", dropped_count); end
    checks++; if (s_dropped !== 3'd7 || s_kept !== 3'd0) begin
      errors++; $display("FAIL saturate got %0d/%0d exp 0/7", s_kept, s_dropped); end
  endtask

  task automatic test_reset_mid();
    write_cfg(4'b0111, 3'd3, 2'b00, 32'h0, 32'h0, 1'b0, ADDI);
    issue(1'b1, JAL, 1'b0);
    issue(1'b1, ADDI, 1'b0);
    checks++; if (drop_instr !== 1'b0) begin errors++; $display("FAIL pre_reset got %b exp 0", drop_instr); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (drop_instr !== 1'b1 || dut.trail_q !== 3'd0) begin
      errors++; $display("FAIL mid_reset got drop=%b trail=%0d exp drop=1 trail=0", drop_instr, dut.trail_q); end
    checks++; if (dropped_count !== 32'd0 || event_class !== 4'h0) begin
      errors++; $display("FAIL mid_reset_state got cnt=%0d ev=%h exp 0/0", dropped_count, event_class); end
    @(negedge clk); rst_n = 1'b1;
    issue(1'b1, ADDI, 1'b0);
    checks++; if (drop_instr !== 1'b1) begin errors++; $display("FAIL post_reset got %b exp 1", drop_instr); end
  endtask

  initial begin
    pc_valid = 1'b0; next_instr = '0; cfg_wr = 1'b0; cfg_class_en = '0;
    cfg_trailing = '0; cfg_mode = '0; cfg_match_value = '0; cfg_match_mask = '0;
    cnt_clear = 1'b0; rst_n = 1'b0;
    test_reset();
    test_default();
    test_long_window();
    test_reload_stall();
    test_custom_wfi();
    test_modes();
    test_counters();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
